uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous serial line into `WIDTH`-bit words. Each word is presented with a single-cycle `valid` strobe. The block sits directly upstream of the 8-bit register stage: `data_out` drives that stage's `in`, and `valid` drives its `wr_en`. A received byte is therefore captured one clock after `valid`.

---
 rtl/uart_rx_pkg.sv | 9 +
 rtl/uart_rx_sync_2ff.sv | 17 +
 rtl/uart_rx.sv | 79 +++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM state encodings and default frame parameters shared by the UART blocks
package uart_rx_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  localparam int DEF_WIDTH        = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: 1-bit two-stage synchroniser (clk, rst active-low async to 1, d async in, q synced out)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver (clk, rst active-low async, rx serial in; data_out word, valid/frame_err strobes, busy)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  logic             rx_s;
  logic             rx_d;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_d      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_d      <= rx_s;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (rx_d && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        START:
          if (cnt == HALF) begin
            state   <= rx_s ? IDLE : DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == FULL) begin
            // shifting in from the top leaves bit 0 in the LSB after WIDTH bits
            shreg   <= {rx_s, shreg[WIDTH-1:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST) state <= STOP;
          end else cnt <= cnt + 1'b1;
        default:
          if (cnt == FULL) begin
            state <= IDLE;
            cnt   <= '0;
            if (rx_s) begin
              data_out <= shreg;
              valid    <= 1'b1;
            end else frame_err <= 1'b1;
          end else cnt <= cnt + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-timing reference model
module tb_uart_rx;
  localparam int W = 8;
  localparam int C = 16;
  logic clk_tb = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic [W-1:0] data_out;
  logic valid, frame_err, busy;
  logic [7:0] reg_q;
  always #5 clk_tb = ~clk_tb;
  uart_rx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk_tb),
    .rst(rst),
    .rx(rx),
    .data_out(data_out),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );
  always_ff @(posedge clk_tb or negedge rst)
    if (!rst) reg_q <= '0;
    else if (valid) reg_q <= data_out;
  int checks = 0;
  int fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  int edge_n = 0;
  bit m_s1 = 1, m_s2 = 1, m_prev = 1, m_rs;
  bit m_busy = 0, m_valid = 0, m_ferr = 0;
  logic [7:0] m_data = '0, m_bits = '0, m_reg = '0;
  int m_d = 0, m_k = 0;
  // Reference: timestamps relative to the detected start edge D decide every sample point
  always @(posedge clk_tb) begin
    edge_n++;
    if (!rst) begin
      m_s1 = 1; m_s2 = 1; m_prev = 1; m_busy = 0; m_valid = 0; m_ferr = 0;
      m_data = '0; m_bits = '0; m_reg = '0;
    end else begin
      m_rs = m_s2;
      m_s2 = m_s1;
      m_s1 = rx;
      if (m_valid) m_reg = m_data;
      m_valid = 0;
      m_ferr = 0;
      if (!m_busy) begin
        if (m_prev && !m_rs) begin
          m_busy = 1;
          m_d = edge_n;
        end
      end else begin
        m_k = edge_n - m_d;
        if (m_k == C / 2) begin
          if (m_rs) m_busy = 0;
        end else if (m_k == C / 2 + (W + 1) * C) begin
          m_busy = 0;
          if (m_rs) begin
            m_valid = 1;
            m_data = m_bits;
          end else m_ferr = 1;
        end else if (m_k > C / 2 && (m_k - C / 2) % C == 0)
          m_bits[(m_k - C / 2) / C - 1] = m_rs;
      end
      m_prev = m_rs;
    end
  end
  int n_valid = 0, n_ferr = 0, n_busy = 0, last_valid_edge = 0;
  logic [7:0] last_data = '0;
  always @(negedge clk_tb) begin
    check("valid", 32'(valid), 32'(m_valid));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("data_out", 32'(data_out), 32'(m_data));
    check("busy", 32'(busy), 32'(m_busy));
    check("reg_stage", 32'(reg_q), 32'(m_reg));
    if (valid) begin
      n_valid++;
      last_valid_edge = edge_n;
      last_data = data_out;
    end
    if (frame_err) n_ferr++;
    if (busy) n_busy++;
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk_tb);
  endtask
  task automatic send(input logic [7:0] b, input bit stop, output int t0);
    t0 = edge_n;
    rx = 1'b0;
    idle(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(C);
    end
    rx = stop;
    idle(C);
  endtask
  int t0, t1, nv, nf, nb;
  logic [7:0] rb;
  initial begin
    idle(3);
    check("reset_data", 32'(data_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    idle(10);
    send(8'h55, 1'b1, t0);
    idle(20);
    check("x55_count", 32'(n_valid), 32'd1);
    check("x55_data", 32'(last_data), 32'h55);
    check("x55_edge", 32'(last_valid_edge), 32'(t0 + 155));
    check("x55_ferr", 32'(n_ferr), 32'd0);
    send(8'hA3, 1'b1, t0);
    t1 = last_valid_edge;
    send(8'h0F, 1'b1, t0);
    idle(20);
    check("b2b_count", 32'(n_valid), 32'd3);
    check("b2b_gap", 32'(last_valid_edge - t1), 32'd160);
    check("b2b_data", 32'(data_out), 32'h0F);
    nv = n_valid; nf = n_ferr; nb = n_busy;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    check("glitch_busy_cycles", 32'(n_busy - nb), 32'd8);
    check("glitch_no_valid", 32'(n_valid - nv), 32'd0);
    check("glitch_no_ferr", 32'(n_ferr - nf), 32'd0);
    nv = n_valid; nf = n_ferr;
    send(8'h3C, 1'b0, t0);
    nb = n_busy;
    idle(40);
    check("ferr_count", 32'(n_ferr - nf), 32'd1);
    check("ferr_no_valid", 32'(n_valid - nv), 32'd0);
    check("ferr_data_kept", 32'(data_out), 32'h0F);
    check("ferr_low_no_restart", 32'(n_busy - nb), 32'd0);
    rx = 1'b1;
    idle(10);
    rb = 8'hE5;
    rx = 1'b0;
    idle(C);
    for (int i = 0; i < 5; i++) begin
      rx = rb[i];
      idle(C);
    end
    rx = 1'b1;
    idle(2);
    nv = n_valid;
    #3 rst = 1'b0;
    #1;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    idle(5);
    rst = 1'b1;
    idle(5 * C);
    check("rst_no_valid", 32'(n_valid - nv), 32'd0);
    send(8'h81, 1'b1, t0);
    idle(10);
    check("x81_data", 32'(last_data), 32'h81);
    check("x81_edge", 32'(last_valid_edge), 32'(t0 + 155));
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 20));
      if ($urandom_range(0, 5) == 0) begin
        rx = 1'b0;
        idle($urandom_range(1, 6));
        rx = 1'b1;
        idle(12);
      end else begin
        send(8'($urandom), $urandom_range(0, 4) != 0, t0);
        rx = 1'b1;
      end
    end
    idle(30);
    send(8'h5A, 1'b1, t0);
    idle(40);
    check("reg_stage_5a", 32'(reg_q), 32'h5A);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
